// File: rtl/uart_boot_loader_if.sv
// rtl/uart_boot_loader_if.sv - UART byte input and RAM word write port of the boot loader
interface uart_boot_loader_if #(
    parameter int ADDR_W = 13
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [ADDR_W-1:0] ram_addres;
    logic [31:0]       data_to_mem;
    logic              RAM_WE;

    modport master (output rx_data, rx_valid, input ram_addres, data_to_mem, RAM_WE);
    modport slave  (input rx_data, rx_valid, output ram_addres, data_to_mem, RAM_WE);
endinterface

// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - UART frame loader into word RAM, then core release; BOOT_CHECKSUM_EN adds XOR check
module uart_boot_loader #(
    parameter int         ADDR_W         = 13,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
    input  logic                clk,
    input  logic                rst_n,
    uart_boot_loader_if.slave   bus,
    output logic                core_ena,
    output logic [1:0]          boot_err
);
    localparam int          IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
`ifdef BOOT_CHECKSUM_EN
        CSUM,
`endif
        RUN,
        ERROR
    } state_t;

`ifdef BOOT_CHECKSUM_EN
    localparam state_t DONE_STATE = CSUM;
`else
    localparam state_t DONE_STATE = RUN;
`endif

    state_t            state;
    logic [1:0]        byte_cnt;
    logic [ADDR_W-1:0] word_idx;
    logic [15:0]       words_left;
    logic [IDLE_W-1:0] idle_cnt;
    logic [7:0]        len_lo;
    logic [23:0]       word_buf;
    logic              timed;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    always_comb begin
        timed = 1'b0;
        case (state)
            LEN_LO, LEN_HI, DATA: timed = 1'b1;
`ifdef BOOT_CHECKSUM_EN
            CSUM:                 timed = 1'b1;
`endif
            default:              timed = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            bus.RAM_WE      <= 1'b0;
            bus.ram_addres  <= '0;
            bus.data_to_mem <= '0;
            core_ena        <= 1'b0;
            boot_err        <= 2'd0;
            byte_cnt        <= 2'd0;
            word_idx        <= '0;
            words_left      <= 16'd0;
            idle_cnt        <= '0;
            len_lo          <= 8'd0;
            word_buf        <= 24'd0;
`ifdef BOOT_CHECKSUM_EN
            csum            <= 8'd0;
`endif
        end else begin
            bus.RAM_WE <= 1'b0;
            // Release the core one cycle after RUN so the final write lands first
            core_ena   <= (state == RUN);

            // A byte arriving on the expiry cycle takes priority over the timeout
            if (!timed || bus.rx_valid) begin
                idle_cnt <= '0;
            end else if (idle_cnt == IDLE_W'(TIMEOUT_CYCLES)) begin
                state    <= ERROR;
                boot_err <= 2'd3;
            end else begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end

            if (bus.rx_valid) begin
                case (state)
                    IDLE: begin
                        if (bus.rx_data == SYNC_BYTE) begin
                            state    <= LEN_LO;
                            byte_cnt <= 2'd0;
                            word_idx <= '0;
`ifdef BOOT_CHECKSUM_EN
                            csum     <= 8'd0;
`endif
                        end
                    end
                    LEN_LO: begin
                        len_lo <= bus.rx_data;
                        state  <= LEN_HI;
                    end
                    LEN_HI: begin
                        words_left <= {bus.rx_data, len_lo};
                        if ({17'd0, bus.rx_data, len_lo} > MAX_WORDS) begin
                            state    <= ERROR;
                            boot_err <= 2'd1;
                        end else if ({bus.rx_data, len_lo} == 16'd0) begin
                            state <= DONE_STATE;
                        end else begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
`ifdef BOOT_CHECKSUM_EN
                        csum <= csum ^ bus.rx_data;
`endif
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            bus.RAM_WE      <= 1'b1;
                            bus.data_to_mem <= {bus.rx_data, word_buf};
                            bus.ram_addres  <= word_idx;
                            word_idx        <= word_idx + ADDR_W'(1);
                            words_left      <= words_left - 16'd1;
                            if (words_left == 16'd1) state <= DONE_STATE;
                        end else begin
                            word_buf <= {bus.rx_data, word_buf[23:8]};
                        end
                    end
`ifdef BOOT_CHECKSUM_EN
                    CSUM: begin
                        if (bus.rx_data == csum) begin
                            state <= RUN;
                        end else begin
                            state    <= ERROR;
                            boot_err <= 2'd2;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end
endmodule
